// File: rtl/alu_calc_unit.sv
// alu_calc_unit: single-stage ALU execution unit. It sits between the ALU
// reservation station and the CDB arbiter, with a valid/ready handshake on
// both sides.
// Optional feature macro: ALU_SKID_BUF_EN. When it is defined, the unit has
// a second (skid) result slot and a registered in_ready. The default build
// has one result slot and a combinational in_ready.
// The instruction type codes follow the info.v numbering and are reproduced
// locally below. Only the calc-class codes matter here; any other code is
// accepted and dropped.

`default_nettype none

module alu_calc_unit #(
    parameter int ROB_TAG_W       = 4,
    parameter int INST_TYPE_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rdy,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INST_TYPE_WIDTH-1:0] in_type,
    input  logic [31:0]                in_vj,
    input  logic [31:0]                in_vk,
    input  logic [31:0]                in_imm,
    input  logic [31:0]                in_pc,
    input  logic [ROB_TAG_W-1:0]       in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_value,
    output logic [ROB_TAG_W-1:0]       out_tag
);

    localparam logic [INST_TYPE_WIDTH-1:0] T_LUI   = INST_TYPE_WIDTH'(1);
    localparam logic [INST_TYPE_WIDTH-1:0] T_AUIPC = INST_TYPE_WIDTH'(2);
    localparam logic [INST_TYPE_WIDTH-1:0] T_ADDI  = INST_TYPE_WIDTH'(19);
    localparam logic [INST_TYPE_WIDTH-1:0] T_SLTI  = INST_TYPE_WIDTH'(20);
    localparam logic [INST_TYPE_WIDTH-1:0] T_SLTIU = INST_TYPE_WIDTH'(21);
    localparam logic [INST_TYPE_WIDTH-1:0] T_XORI  = INST_TYPE_WIDTH'(22);
    localparam logic [INST_TYPE_WIDTH-1:0] T_ORI   = INST_TYPE_WIDTH'(23);
    localparam logic [INST_TYPE_WIDTH-1:0] T_ANDI  = INST_TYPE_WIDTH'(24);
    localparam logic [INST_TYPE_WIDTH-1:0] T_SLLI  = INST_TYPE_WIDTH'(25);
    localparam logic [INST_TYPE_WIDTH-1:0] T_SRLI  = INST_TYPE_WIDTH'(26);
    localparam logic [INST_TYPE_WIDTH-1:0] T_SRAI  = INST_TYPE_WIDTH'(27);
    localparam logic [INST_TYPE_WIDTH-1:0] T_ADD   = INST_TYPE_WIDTH'(28);
    localparam logic [INST_TYPE_WIDTH-1:0] T_SUB   = INST_TYPE_WIDTH'(29);
    localparam logic [INST_TYPE_WIDTH-1:0] T_SLL   = INST_TYPE_WIDTH'(30);
    localparam logic [INST_TYPE_WIDTH-1:0] T_SLT   = INST_TYPE_WIDTH'(31);
    localparam logic [INST_TYPE_WIDTH-1:0] T_SLTU  = INST_TYPE_WIDTH'(32);
    localparam logic [INST_TYPE_WIDTH-1:0] T_XOR   = INST_TYPE_WIDTH'(33);
    localparam logic [INST_TYPE_WIDTH-1:0] T_SRL   = INST_TYPE_WIDTH'(34);
    localparam logic [INST_TYPE_WIDTH-1:0] T_SRA   = INST_TYPE_WIDTH'(35);
    localparam logic [INST_TYPE_WIDTH-1:0] T_OR    = INST_TYPE_WIDTH'(36);
    localparam logic [INST_TYPE_WIDTH-1:0] T_AND   = INST_TYPE_WIDTH'(37);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    logic [4:0]  shamt_reg;
    logic [4:0]  shamt_imm;
    logic        lt_signed_reg;
    logic        lt_signed_imm;
    logic        lt_unsigned_reg;
    logic        lt_unsigned_imm;
    logic        is_calc;
    logic [31:0] calc_result;
    logic        accept;
    logic        retire;
    logic        take;

    slot_state_e          prim_state_q, prim_state_d;
    logic [31:0]          prim_value_q, prim_value_d;
    logic [ROB_TAG_W-1:0] prim_tag_q,   prim_tag_d;

`ifdef ALU_SKID_BUF_EN
    slot_state_e          skid_state_q, skid_state_d;
    logic [31:0]          skid_value_q, skid_value_d;
    logic [ROB_TAG_W-1:0] skid_tag_q,   skid_tag_d;
    logic                 in_ready_q,   in_ready_d;
`endif

    assign shamt_reg       = in_vk[4:0];
    assign shamt_imm       = in_imm[4:0];
    assign lt_signed_reg   = $signed(in_vj) < $signed(in_vk);
    assign lt_signed_imm   = $signed(in_vj) < $signed(in_imm);
    assign lt_unsigned_reg = in_vj < in_vk;
    assign lt_unsigned_imm = in_vj < in_imm;

    // Decode the instruction type and compute its result; unknown codes are flagged non-calc
    always_comb begin
        is_calc     = 1'b1;
        calc_result = 32'd0;
        case (in_type)
            T_LUI:   calc_result = in_imm;
            T_AUIPC: calc_result = in_pc + in_imm;
            T_ADDI:  calc_result = in_vj + in_imm;
            T_SLTI:  calc_result = {31'd0, lt_signed_imm};
            T_SLTIU: calc_result = {31'd0, lt_unsigned_imm};
            T_XORI:  calc_result = in_vj ^ in_imm;
            T_ORI:   calc_result = in_vj | in_imm;
            T_ANDI:  calc_result = in_vj & in_imm;
            T_SLLI:  calc_result = in_vj << shamt_imm;
            T_SRLI:  calc_result = in_vj >> shamt_imm;
            T_SRAI:  calc_result = $unsigned($signed(in_vj) >>> shamt_imm);
            T_ADD:   calc_result = in_vj + in_vk;
            T_SUB:   calc_result = in_vj - in_vk;
            T_SLL:   calc_result = in_vj << shamt_reg;
            T_SLT:   calc_result = {31'd0, lt_signed_reg};
            T_SLTU:  calc_result = {31'd0, lt_unsigned_reg};
            T_XOR:   calc_result = in_vj ^ in_vk;
            T_SRL:   calc_result = in_vj >> shamt_reg;
            T_SRA:   calc_result = $unsigned($signed(in_vj) >>> shamt_reg);
            T_OR:    calc_result = in_vj | in_vk;
            T_AND:   calc_result = in_vj & in_vk;
            default: is_calc = 1'b0;
        endcase
    end

    // A flushed input still completes its handshake but never lands in a slot.
    assign accept = in_valid && in_ready && rdy;
    assign retire = out_valid && out_ready && rdy;
    assign take   = accept && is_calc && !clr;

    assign out_valid = (prim_state_q == SLOT_FULL);
    assign out_value = prim_value_q;
    assign out_tag   = prim_tag_q;

`ifdef ALU_SKID_BUF_EN

    assign in_ready = in_ready_q;

    // Two-entry FIFO: retire shifts skid into primary, then a new result fills the first free slot
    always_comb begin
        prim_state_d = prim_state_q;
        prim_value_d = prim_value_q;
        prim_tag_d   = prim_tag_q;
        skid_state_d = skid_state_q;
        skid_value_d = skid_value_q;
        skid_tag_d   = skid_tag_q;
        if (rdy) begin
            if (clr) begin
                prim_state_d = SLOT_EMPTY;
                skid_state_d = SLOT_EMPTY;
            end else begin
                if (retire) begin
                    if (skid_state_q == SLOT_FULL) begin
                        prim_state_d = SLOT_FULL;
                        prim_value_d = skid_value_q;
                        prim_tag_d   = skid_tag_q;
                        skid_state_d = SLOT_EMPTY;
                    end else begin
                        prim_state_d = SLOT_EMPTY;
                    end
                end
                if (take) begin
                    if (prim_state_d == SLOT_EMPTY) begin
                        prim_state_d = SLOT_FULL;
                        prim_value_d = calc_result;
                        prim_tag_d   = in_tag;
                    end else begin
                        skid_state_d = SLOT_FULL;
                        skid_value_d = calc_result;
                        skid_tag_d   = in_tag;
                    end
                end
            end
        end
        in_ready_d = (skid_state_d == SLOT_EMPTY);
    end

`else

    assign in_ready = (prim_state_q == SLOT_EMPTY) || out_ready;

    // Single slot: a new result overwrites on accept, otherwise a retire empties it
    always_comb begin
        prim_state_d = prim_state_q;
        prim_value_d = prim_value_q;
        prim_tag_d   = prim_tag_q;
        if (rdy) begin
            if (clr) begin
                prim_state_d = SLOT_EMPTY;
            end else if (take) begin
                prim_state_d = SLOT_FULL;
                prim_value_d = calc_result;
                prim_tag_d   = in_tag;
            end else if (retire) begin
                prim_state_d = SLOT_EMPTY;
            end
        end
    end

`endif

    // Slot registers, cleared immediately by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prim_state_q <= SLOT_EMPTY;
            prim_value_q <= 32'd0;
            prim_tag_q   <= '0;
`ifdef ALU_SKID_BUF_EN
            skid_state_q <= SLOT_EMPTY;
            skid_value_q <= 32'd0;
            skid_tag_q   <= '0;
            in_ready_q   <= 1'b1;
`endif
        end else begin
            prim_state_q <= prim_state_d;
            prim_value_q <= prim_value_d;
            prim_tag_q   <= prim_tag_d;
`ifdef ALU_SKID_BUF_EN
            skid_state_q <= skid_state_d;
            skid_value_q <= skid_value_d;
            skid_tag_q   <= skid_tag_d;
            in_ready_q   <= in_ready_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_calc_unit.sv
// Testbench for alu_calc_unit. It runs directed scenarios and then a
// randomized phase. The reference is a result queue whose capacity is 1 in
// the default build and 2 when ALU_SKID_BUF_EN is defined.

module tb_alu_calc_unit;

    localparam logic [5:0] T_LUI   = 6'd1;
    localparam logic [5:0] T_AUIPC = 6'd2;
    localparam logic [5:0] T_BEQ   = 6'd5;
    localparam logic [5:0] T_ADDI  = 6'd19;
    localparam logic [5:0] T_SLTI  = 6'd20;
    localparam logic [5:0] T_SLTIU = 6'd21;
    localparam logic [5:0] T_XORI  = 6'd22;
    localparam logic [5:0] T_ORI   = 6'd23;
    localparam logic [5:0] T_ANDI  = 6'd24;
    localparam logic [5:0] T_SLLI  = 6'd25;
    localparam logic [5:0] T_SRLI  = 6'd26;
    localparam logic [5:0] T_SRAI  = 6'd27;
    localparam logic [5:0] T_ADD   = 6'd28;
    localparam logic [5:0] T_SUB   = 6'd29;
    localparam logic [5:0] T_SLL   = 6'd30;
    localparam logic [5:0] T_SLT   = 6'd31;
    localparam logic [5:0] T_SLTU  = 6'd32;
    localparam logic [5:0] T_XOR   = 6'd33;
    localparam logic [5:0] T_SRL   = 6'd34;
    localparam logic [5:0] T_SRA   = 6'd35;
    localparam logic [5:0] T_OR    = 6'd36;
    localparam logic [5:0] T_AND   = 6'd37;

    typedef struct {
        logic [31:0] value;
        logic [3:0]  tag;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_type;
    logic [31:0] in_vj;
    logic [31:0] in_vk;
    logic [31:0] in_imm;
    logic [31:0] in_pc;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_value;
    logic [3:0]  out_tag;

    int   tests_run;
    int   tests_failed;
    res_t model_q[$];

    alu_calc_unit #(
        .ROB_TAG_W(4),
        .INST_TYPE_WIDTH(6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rdy(rdy),
        .clr(clr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_type(in_type),
        .in_vj(in_vj),
        .in_vk(in_vk),
        .in_imm(in_imm),
        .in_pc(in_pc),
        .in_tag(in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_value(out_value),
        .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic isCalc(input logic [5:0] t);
        return (t == T_LUI) || (t == T_AUIPC) || ((t >= T_ADDI) && (t <= T_AND));
    endfunction

    // Shifts are expressed as multiply/divide by powers of two
    function automatic logic [31:0] refResult(input logic [5:0] t, input logic [31:0] vj,
                                              input logic [31:0] vk, input logic [31:0] imm,
                                              input logic [31:0] pc);
        logic [31:0] b;
        logic [31:0] pow2;
        int          sa;
        int          sb;
        logic        use_imm;
        use_imm = (t >= T_ADDI) && (t <= T_SRAI);
        b       = use_imm ? imm : vk;
        pow2    = 32'd1 << b[4:0];
        sa      = vj;
        sb      = b;
        case (t)
            T_LUI:            return imm;
            T_AUIPC:          return pc + imm;
            T_ADD, T_ADDI:    return vj + b;
            T_SUB:            return vj - b;
            T_SLL, T_SLLI:    return vj * pow2;
            T_SRL, T_SRLI:    return vj / pow2;
            T_SRA, T_SRAI:    return vj[31] ? ~((~vj) / pow2) : (vj / pow2);
            T_SLT, T_SLTI:    return (sa < sb) ? 32'd1 : 32'd0;
            T_SLTU, T_SLTIU:  return (vj < b) ? 32'd1 : 32'd0;
            T_XOR, T_XORI:    return vj ^ b;
            T_OR, T_ORI:      return vj | b;
            T_AND, T_ANDI:    return vj & b;
            default:          return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic checkBit(input string name, input logic observed, input logic expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %b expected %b", name, observed, expected);
        end
    endtask

    task automatic checkWord(input string name, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [5:0] t, input logic [31:0] vj,
                                 input logic [31:0] vk, input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [3:0] tg, input logic ordy, input logic r, input logic c);
        in_valid  = iv;
        in_type   = t;
        in_vj     = vj;
        in_vk     = vk;
        in_imm    = imm;
        in_pc     = pc;
        in_tag    = tg;
        out_ready = ordy;
        rdy       = r;
        clr       = c;
    endtask

    // Called at a falling edge: compare outputs against the model, cross the rising edge, update the model
    task automatic checkOutput();
        logic exp_in_ready;
        logic exp_out_valid;
        logic acc;
        logic ret;
        res_t head;
        res_t item;
        #1;
        exp_out_valid = (model_q.size() != 0);
`ifdef ALU_SKID_BUF_EN
        exp_in_ready = (model_q.size() < 2);
`else
        exp_in_ready = (model_q.size() == 0) || out_ready;
`endif
        checkBit("in_ready", in_ready, exp_in_ready);
        checkBit("out_valid", out_valid, exp_out_valid);
        if (exp_out_valid) begin
            head = model_q[0];
            checkWord("out_value", out_value, head.value);
            checkWord("out_tag", {28'd0, out_tag}, {28'd0, head.tag});
        end
        acc        = in_valid && exp_in_ready && rdy;
        ret        = exp_out_valid && out_ready && rdy;
        item.value = refResult(in_type, in_vj, in_vk, in_imm, in_pc);
        item.tag   = in_tag;
        @(posedge clk);
        if (rst_n && rdy) begin
            if (clr) begin
                model_q.delete();
            end else begin
                if (ret) void'(model_q.pop_front());
                if (acc && isCalc(in_type)) model_q.push_back(item);
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input logic iv, input logic [5:0] t, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tg,
                        input logic ordy, input logic r, input logic c);
        applyStimulus(iv, t, vj, vk, imm, pc, tg, ordy, r, c);
        checkOutput();
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, T_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, ordy, 1'b1, 1'b0);
    endtask

    task automatic issueAndExpect(input string name, input logic [5:0] t, input logic [31:0] vj,
                                  input logic [31:0] vk, input logic [31:0] imm, input logic [31:0] pc,
                                  input logic [3:0] tg, input logic [31:0] expv);
        step(1'b1, t, vj, vk, imm, pc, tg, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, T_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        #1;
        checkBit({name, "_valid"}, out_valid, 1'b1);
        checkWord({name, "_value"}, out_value, expv);
        checkWord({name, "_tag"}, {28'd0, out_tag}, {28'd0, tg});
        checkOutput();
    endtask

    initial begin
        logic [31:0] imm_raw;
        logic [31:0] imm_v;
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        applyStimulus(1'b0, T_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        checkBit("reset_out_valid", out_valid, 1'b0);
        checkBit("reset_in_ready", in_ready, 1'b1);
        checkWord("reset_out_value", out_value, 32'd0);
        checkWord("reset_out_tag", {28'd0, out_tag}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issueAndExpect("addi", T_ADDI, 32'd5, 32'd0, 32'hFFFF_FFF9, 32'd0, 4'd3, 32'hFFFF_FFFE);
        issueAndExpect("sra", T_SRA, 32'h8000_0000, 32'h24, 32'd0, 32'd0, 4'd4, 32'hF800_0000);
        issueAndExpect("sltu", T_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd5, 32'd1);
        issueAndExpect("slt", T_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd6, 32'd0);
        issueAndExpect("auipc", T_AUIPC, 32'd0, 32'd0, 32'h2000, 32'h1000, 4'd7, 32'h3000);
        idle(1'b1, 2);

        // Backpressure: three stalled cycles with input streaming, then drain in order
        step(1'b1, T_ADD, 32'd10, 32'd1, 32'd0, 32'd0, 4'd8, 1'b0, 1'b1, 1'b0);
        step(1'b1, T_SUB, 32'd10, 32'd1, 32'd0, 32'd0, 4'd9, 1'b0, 1'b1, 1'b0);
        step(1'b1, T_XOR, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 4'd10, 1'b0, 1'b1, 1'b0);
        step(1'b1, T_OR, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 4'd11, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 3);

        // Flush while full with a same-cycle input that must never surface
        step(1'b1, T_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 4'd1, 1'b0, 1'b1, 1'b0);
        step(1'b1, T_ADD, 32'd3, 32'd4, 32'd0, 32'd0, 4'd2, 1'b0, 1'b1, 1'b0);
        step(1'b1, T_ADD, 32'd5, 32'd6, 32'd0, 32'd0, 4'd12, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, T_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        #1;
        checkBit("flush_out_valid", out_valid, 1'b0);
        checkOutput();
        idle(1'b1, 2);

        // Non-calc code is consumed without producing a result
        step(1'b1, T_BEQ, 32'd1, 32'd1, 32'd8, 32'h40, 4'd13, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, T_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        #1;
        checkBit("noncalc_out_valid", out_valid, 1'b0);
        checkOutput();

        // Global enable low for two cycles mid-stream
        step(1'b1, T_SLL, 32'd3, 32'd4, 32'd0, 32'd0, 4'd14, 1'b0, 1'b1, 1'b0);
        step(1'b1, T_AND, 32'hFF, 32'h0F, 32'd0, 32'd0, 4'd15, 1'b1, 1'b0, 1'b0);
        step(1'b1, T_AND, 32'hFF, 32'h0F, 32'd0, 32'd0, 4'd15, 1'b1, 1'b0, 1'b0);
        step(1'b1, T_SRL, 32'h100, 32'd4, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 3);

        // Randomized traffic including stalls, enable drops and occasional flushes
        for (int i = 0; i < 400; i++) begin
            imm_raw = $urandom();
            imm_v   = {{20{imm_raw[11]}}, imm_raw[11:0]};
            if ($urandom_range(0, 4) == 0) imm_v = randOperand();
            step(($urandom_range(0, 9) < 7), 6'($urandom_range(0, 37)), randOperand(), randOperand(),
                 imm_v, $urandom(), 4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 31) == 0));
        end

        // Asynchronous reset in the middle of stalled traffic
        step(1'b1, T_ADD, 32'd7, 32'd8, 32'd0, 32'd0, 4'd5, 1'b0, 1'b1, 1'b0);
        step(1'b1, T_ADD, 32'd9, 32'd8, 32'd0, 32'd0, 4'd6, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, T_ADD, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checkBit("async_reset_out_valid", out_valid, 1'b0);
        checkBit("async_reset_in_ready", in_ready, 1'b1);
        checkWord("async_reset_out_value", out_value, 32'd0);
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issueAndExpect("post_reset_lui", T_LUI, 32'd0, 32'd0, 32'h1234_5000, 32'd0, 4'd9, 32'h1234_5000);
        idle(1'b1, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
